// File: rtl/rv_decode_stage_if.sv
// Fetch-side, execute-side and hazard signals of the RV32I decode stage.
interface rv_decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic             flush;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             out_valid;
  logic             out_ready;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic [4:0]       alu_ctrl;
  logic [2:0]       br_type;
  logic             jal;
  logic             jalr;
  logic             lui;
  logic             auipc;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc_out;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, instr, pc, flush, ex_mem_read, ex_rd, out_ready,
    output in_ready, out_valid, mem_read, mem_to_reg, mem_write, alu_src,
           reg_write, alu_ctrl, br_type, jal, jalr, lui, auipc, rs1, rs2,
           rd, imm, pc_out, illegal, stall_cnt
  );

  modport master (
    output in_valid, instr, pc, flush, ex_mem_read, ex_rd, out_ready,
    input  in_ready, out_valid, mem_read, mem_to_reg, mem_write, alu_src,
           reg_write, alu_ctrl, br_type, jal, jalr, lui, auipc, rs1, rs2,
           rd, imm, pc_out, illegal, stall_cnt
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I(M) decode stage: valid/ready output register, load-use stall,
// branch flush and a saturating stall-cycle counter.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter bit          RV32M = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  rv_decode_stage_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  typedef struct packed {
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [4:0]      alu_ctrl;
    logic [2:0]      br_type;
    logic            jal;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];

  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                  bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_u = {bus.instr[31:12], 12'b0};
  assign imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                  bus.instr[20], bus.instr[30:21], 1'b0};

  bundle_t          dec;
  bundle_t          q;
  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       base_alu;
  logic             is_shift;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             hazard;
  logic             in_ready_c;

  // ALU code shared by register and immediate arithmetic; func7 picks SRL/SRA
  always_comb begin
    base_alu = 5'd0;
    case (f3)
      3'b000: base_alu = 5'd0;
      3'b001: base_alu = 5'd2;
      3'b010: base_alu = 5'd3;
      3'b011: base_alu = 5'd4;
      3'b100: base_alu = 5'd5;
      3'b101: base_alu = (f7 == F7_ALT) ? 5'd7 : 5'd6;
      3'b110: base_alu = 5'd8;
      default: base_alu = 5'd9;
    endcase
  end

  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec     = '0;
    dec.rs1 = bus.instr[19:15];
    dec.rs2 = bus.instr[24:20];
    dec.rd  = bus.instr[11:7];
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (f7 == F7_BASE)
          dec.alu_ctrl = base_alu;
        else if (f7 == F7_ALT && f3 == 3'b000)
          dec.alu_ctrl = 5'd1;
        else if (f7 == F7_ALT && f3 == 3'b101)
          dec.alu_ctrl = base_alu;
        else if (f7 == F7_MUL && RV32M)
          dec.alu_ctrl = {2'b10, f3};
        else
          dec.illegal = 1'b1;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = XLEN'(imm_i);
        if (is_shift && f7 != F7_BASE && f7 != F7_ALT)
          dec.illegal = 1'b1;
        else
          dec.alu_ctrl = base_alu;
      end
      OP_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm        = XLEN'(imm_i);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = XLEN'(imm_s);
        dec.rd        = 5'd0;
      end
      OP_BRANCH: begin
        dec.alu_ctrl = 5'd1;
        dec.imm      = XLEN'(imm_b);
        dec.rd       = 5'd0;
        case (f3)
          3'b000:  dec.br_type = 3'd1;
          3'b001:  dec.br_type = 3'd2;
          3'b100:  dec.br_type = 3'd3;
          3'b101:  dec.br_type = 3'd4;
          3'b110:  dec.br_type = 3'd5;
          3'b111:  dec.br_type = 3'd6;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = XLEN'(imm_j);
      end
      OP_JALR: begin
        dec.jalr      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = XLEN'(imm_i);
        dec.illegal   = (f3 != 3'b000);
      end
      OP_LUI: begin
        dec.lui       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = 5'd10;
        dec.imm       = XLEN'(imm_u);
      end
      OP_AUIPC: begin
        dec.auipc     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = XLEN'(imm_u);
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal encoding must not change architectural state or redirect
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.jal       = 1'b0;
      dec.jalr      = 1'b0;
      dec.br_type   = 3'd0;
    end
  end

  assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign hazard   = bus.in_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1 && bus.ex_rd == bus.instr[19:15]) ||
                     (uses_rs2 && bus.ex_rd == bus.instr[24:20]));
  assign in_ready_c = (!valid_q || bus.out_ready) && !hazard && !bus.flush;

  // Output register: flush beats accept, accept beats drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (bus.in_valid && in_ready_c) begin
        valid_q <= 1'b1;
        q       <= dec;
        pc_q    <= bus.pc;
      end else if (bus.out_ready && valid_q) begin
        valid_q <= 1'b0;
      end
      if (hazard && !bus.flush && !(&cnt_q))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = valid_q;
  assign bus.mem_read   = q.mem_read;
  assign bus.mem_to_reg = q.mem_to_reg;
  assign bus.mem_write  = q.mem_write;
  assign bus.alu_src    = q.alu_src;
  assign bus.reg_write  = q.reg_write;
  assign bus.alu_ctrl   = q.alu_ctrl;
  assign bus.br_type    = q.br_type;
  assign bus.jal        = q.jal;
  assign bus.jalr       = q.jalr;
  assign bus.lui        = q.lui;
  assign bus.auipc      = q.auipc;
  assign bus.rs1        = q.rs1;
  assign bus.rs2        = q.rs2;
  assign bus.rd         = q.rd;
  assign bus.imm        = q.imm;
  assign bus.pc_out     = pc_q;
  assign bus.illegal    = q.illegal;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed plus randomized bench for rv_decode_stage with RV32M on and off,
// checked against an ISA-level decode model and a handshake model.
module tb_rv_decode_stage;

  typedef struct packed {
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [4:0]  alu_ctrl;
    logic [2:0]  br_type;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic        illegal;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_decode_stage_if #(.XLEN(32), .CNT_W(16)) ifa ();
  rv_decode_stage_if #(.XLEN(32), .CNT_W(16)) ifb ();

  rv_decode_stage #(.XLEN(32), .RV32M(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  rv_decode_stage #(.XLEN(32), .RV32M(1'b0), .CNT_W(16)) dut_nom (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int      n_vec = 0;
  int      n_err = 0;
  logic    mv;
  bundle_t ma, mb;
  logic [15:0] mcnt;
  logic    last_rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA tables
  function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] p, input bit m);
    bundle_t b;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] alu_tab [8];
    logic [2:0] br_tab [8];
    alu_tab = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    br_tab  = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    b = '0;
    b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7]; b.pc_out = p;
    if (op == 7'h33) begin
      b.reg_write = 1;
      if (f7 == 7'h00) b.alu_ctrl = alu_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) b.alu_ctrl = 5'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) b.alu_ctrl = 5'd7;
      else if (f7 == 7'h01 && m) b.alu_ctrl = 5'(16 + int'(f3));
      else b.illegal = 1;
    end else if (op == 7'h13) begin
      b.reg_write = 1; b.alu_src = 1;
      b.imm = {{20{i[31]}}, i[31:20]};
      if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20) b.illegal = 1;
      else if (f3 == 3'd5 && f7 == 7'h20) b.alu_ctrl = 5'd7;
      else b.alu_ctrl = alu_tab[f3];
    end else if (op == 7'h03) begin
      b.mem_read = 1; b.mem_to_reg = 1; b.reg_write = 1; b.alu_src = 1;
      b.imm = {{20{i[31]}}, i[31:20]};
    end else if (op == 7'h23) begin
      b.mem_write = 1; b.alu_src = 1; b.rd = 0;
      b.imm = {{20{i[31]}}, i[31:25], i[11:7]};
    end else if (op == 7'h63) begin
      b.alu_ctrl = 5'd1; b.rd = 0;
      b.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      b.br_type = br_tab[f3];
      b.illegal = (f3 == 3'd2 || f3 == 3'd3);
    end else if (op == 7'h6F) begin
      b.jal = 1; b.reg_write = 1;
      b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    end else if (op == 7'h67) begin
      b.jalr = 1; b.reg_write = 1; b.alu_src = 1;
      b.imm = {{20{i[31]}}, i[31:20]};
      b.illegal = (f3 != 3'd0);
    end else if (op == 7'h37) begin
      b.lui = 1; b.reg_write = 1; b.alu_src = 1; b.alu_ctrl = 5'd10;
      b.imm = {i[31:12], 12'h000};
    end else if (op == 7'h17) begin
      b.auipc = 1; b.reg_write = 1; b.alu_src = 1;
      b.imm = {i[31:12], 12'h000};
    end else begin
      b.illegal = 1;
    end
    if (b.illegal) begin
      b.reg_write = 0; b.mem_write = 0; b.mem_read = 0;
      b.jal = 0; b.jalr = 0; b.br_type = 0;
    end
    return b;
  endfunction

  function automatic logic ref_hazard(input logic iv, input logic [31:0] i,
                                      input logic emr, input logic [4:0] erd);
    logic [6:0] op;
    logic u1, u2;
    op = i[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return iv && emr && erd != 0 && ((u1 && erd == i[19:15]) || (u2 && erd == i[24:20]));
  endfunction

  function automatic bundle_t obs_a();
    return {ifa.mem_read, ifa.mem_to_reg, ifa.mem_write, ifa.alu_src, ifa.reg_write,
            ifa.alu_ctrl, ifa.br_type, ifa.jal, ifa.jalr, ifa.lui, ifa.auipc,
            ifa.rs1, ifa.rs2, ifa.rd, ifa.imm, ifa.pc_out, ifa.illegal};
  endfunction

  function automatic bundle_t obs_b();
    return {ifb.mem_read, ifb.mem_to_reg, ifb.mem_write, ifb.alu_src, ifb.reg_write,
            ifb.alu_ctrl, ifb.br_type, ifb.jal, ifb.jalr, ifb.lui, ifb.auipc,
            ifb.rs1, ifb.rs2, ifb.rd, ifb.imm, ifb.pc_out, ifb.illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [6:0] op, f7;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    k = $urandom_range(0, 10);
    op = (k < 9) ? ops[k] : 7'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), op};
  endfunction

  // One clock: drive at negedge, check in_ready before the edge, outputs after
  task automatic step(input logic rn, input logic iv, input logic [31:0] ins,
                      input logic [31:0] p, input logic fl, input logic emr,
                      input logic [4:0] erd, input logic ordy);
    logic hz;
    @(negedge clk);
    rst_n = rn;
    ifa.in_valid = iv; ifa.instr = ins; ifa.pc = p; ifa.flush = fl;
    ifa.ex_mem_read = emr; ifa.ex_rd = erd; ifa.out_ready = ordy;
    ifb.in_valid = iv; ifb.instr = ins; ifb.pc = p; ifb.flush = fl;
    ifb.ex_mem_read = emr; ifb.ex_rd = erd; ifb.out_ready = ordy;
    #1;
    hz = ref_hazard(iv, ins, emr, erd);
    last_rdy = (!mv || ordy) && !hz && !fl;
    chk("in_ready_m", 128'(ifa.in_ready), 128'(last_rdy));
    chk("in_ready_nom", 128'(ifb.in_ready), 128'(last_rdy));
    @(posedge clk);
    if (!rn) begin
      mv = 0; ma = '0; mb = '0; mcnt = 0;
    end else begin
      if (fl) mv = 0;
      else if (iv && last_rdy) begin
        ma = ref_decode(ins, p, 1'b1); mb = ref_decode(ins, p, 1'b0); mv = 1;
      end else if (ordy && mv) mv = 0;
      if (hz && !fl && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    end
    #1;
    chk("out_valid_m", 128'(ifa.out_valid), 128'(mv));
    chk("out_valid_nom", 128'(ifb.out_valid), 128'(mv));
    chk("bundle_m", 128'(obs_a()), 128'(ma));
    chk("bundle_nom", 128'(obs_b()), 128'(mb));
    chk("stall_cnt", 128'(ifa.stall_cnt), 128'(mcnt));
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_ADD6 = 32'h00228333;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  initial begin
    mv = 0; ma = '0; mb = '0; mcnt = 0; last_rdy = 0;
    rst_n = 0;
    step(0, 1, I_ADD, 32'h40, 0, 1, 5'd1, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    chk("reset_valid", 128'(ifa.out_valid), 128'(0));
    chk("reset_imm", 128'(ifa.imm), 128'(0));

    step(1, 1, I_ADD, 32'h100, 0, 0, 5'd0, 1);
    chk("add_reg_write", 128'(ifa.reg_write), 128'(1));
    chk("add_fields", 128'({ifa.rd, ifa.rs1, ifa.rs2, ifa.alu_ctrl}),
        128'({5'd3, 5'd1, 5'd2, 5'd0}));

    step(1, 1, I_LW, 32'h104, 0, 0, 5'd0, 1);
    step(1, 1, I_ADD6, 32'h108, 0, 1, 5'd5, 1);
    chk("loaduse_ready", 128'(last_rdy), 128'(0));
    chk("loaduse_bubble", 128'(ifa.out_valid), 128'(0));
    chk("loaduse_cnt", 128'(ifa.stall_cnt), 128'(1));
    step(1, 1, I_ADD6, 32'h108, 0, 0, 5'd0, 1);
    chk("loaduse_accept", 128'({ifa.out_valid, ifa.rd}), 128'({1'b1, 5'd6}));

    step(1, 1, I_BEQ, 32'h10C, 0, 0, 5'd0, 1);
    chk("beq", 128'({ifa.br_type, ifa.imm, ifa.reg_write}),
        128'({3'd1, 32'hFFFFFFFC, 1'b0}));

    for (int k = 0; k < 3; k++) step(1, 1, I_ADD, 32'h110, 0, 0, 5'd0, 0);
    chk("hold_beq", 128'({ifa.out_valid, ifa.br_type}), 128'({1'b1, 3'd1}));
    step(1, 1, I_ADD, 32'h110, 0, 0, 5'd0, 1);
    chk("release_accept", 128'(last_rdy), 128'(1));

    step(1, 1, I_LW, 32'h114, 1, 0, 5'd0, 1);
    chk("flush_ready", 128'(last_rdy), 128'(0));
    chk("flush_valid", 128'(ifa.out_valid), 128'(0));

    step(1, 1, I_MUL, 32'h118, 0, 0, 5'd0, 1);
    chk("mul_m", 128'({ifa.alu_ctrl, ifa.illegal}), 128'({5'd16, 1'b0}));
    chk("mul_nom", 128'({ifb.illegal, ifb.reg_write}), 128'({1'b1, 1'b0}));

    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), rand_instr(),
           $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) < 2),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the RV32I pipeline core.
- Successor to the single-cycle combinational controller. Adds:
  - a valid/ready pipeline register;
  - load-use hazard stall;
  - branch flush;
  - optional M-extension decode;
  - a saturating stall counter.
- Sits between the fetch stage (upstream) and the execute stage (downstream).

Parameters:
- XLEN, 32, width of pc and sign-extended immediate.
- RV32M, 1, 1 = decode MUL/DIV group (func7=0000001); 0 = treat it as illegal.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  decode accepts instr this cycle.
- instr  in  32  instruction word.
- pc  in  XLEN  instruction address.
- flush  in  1  redirect from EX; kill the in-flight decode.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EX accepts the bundle.
- mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  main control signals.
- alu_ctrl  out  5  ALU operation.
- br_type  out  3  branch type.
- jal, jalr, lui, auipc  out  1 each  jump/upper-immediate flags.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  XLEN  sign-extended immediate.
- pc_out  out  XLEN  pc of the bundle.
- illegal  out  1  unsupported encoding.
- stall_cnt  out  CNT_W  count of load-use stall cycles.

Behaviour:

Reset (rst_n=0 at a clk edge):
- out_valid=0, every control output and illegal=0, alu_ctrl=0, br_type=0, imm=0, pc_out=0, rs1/rs2/rd=0, stall_cnt=0.
- A reset mid-stall or mid-handoff discards the bundle; nothing is replayed.

Hazard and handshake:
- uses_rs1: all formats except LUI, AUIPC, JAL.
- uses_rs2: R, STORE, BRANCH only.
- hazard = in_valid & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & ex_rd==instr[19:15]) | (uses_rs2 & ex_rd==instr[24:20])).
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush. This is combinational.

Register update, evaluated each edge with the first matching rule taking priority:
- flush=1 → out_valid<=0. Input is not accepted.
- in_valid & in_ready → load the decoded bundle, out_valid<=1.
- out_ready & out_valid → out_valid<=0. This is the bubble path, including during a hazard.
- Otherwise hold all outputs.

Timing and counter:
- Latency is exactly 1 cycle from acceptance to out_valid.
- Throughput is 1 instruction/cycle when out_ready=1 and there is no hazard.
- stall_cnt increments on each cycle with hazard=1 and flush=0. It saturates at all-ones and never wraps.

Decode rules (opcode → signals; unlisted signals are 0):
- 0110011 R: reg_write. alu_ctrl from func3/func7:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - func7=0000001 with RV32M=1: alu_ctrl = 16+func3 (MUL..REMU).
  - Other func7 values: illegal.
- 0010011 I-ALU: reg_write, alu_src. Same ALU codes as R-type.
  - SRAI when func7=0100000; SUB not possible.
  - Shift with func7 not 0000000/0100000: illegal.
- 0000011 LOAD: mem_read, mem_to_reg, reg_write, alu_src, alu_ctrl=0.
- 0100011 STORE: mem_write, alu_src, alu_ctrl=0.
- 1100011 BRANCH: br_type from func3:
  - 000→1 BEQ, 001→2 BNE, 100→3 BLT, 101→4 BGE, 110→5 BLTU, 111→6 BGEU.
  - 010 or 011: illegal.
  - alu_ctrl=1.
- 1101111 JAL: jal, reg_write.
- 1100111 JALR (func3=000): jalr, reg_write, alu_src.
- 0110111 LUI: lui, reg_write, alu_src, alu_ctrl=10 (pass B).
- 0010111 AUIPC: auipc, reg_write, alu_src, alu_ctrl=0.
- Any other opcode: illegal.

Illegal handling:
- illegal=1 forces reg_write, mem_write, mem_read, jal, jalr to 0 and br_type to 0.

Immediate:
- Formats I/S/B/U/J per the ISA, sign-extended from bit 31 to XLEN.
- R-type imm=0.

Register fields:
- rd = instr[11:7] for every format.
- rd is 0 for STORE/BRANCH.

Test Plan:
- Reset then `add x3,x1,x2` (0x002081B3), in_valid=1, out_ready=1 → next cycle out_valid=1, reg_write=1, alu_ctrl=0, rd=3, rs1=1, rs2=2, illegal=0.
- `lw x5,8(x1)` followed by `add x6,x5,x2`, with ex_mem_read=1 and ex_rd=5 while the add is presented:
  - in_ready=0 for 1 cycle, out_valid=0 (bubble), stall_cnt=1;
  - the add is accepted the next cycle.
- `beq x1,x2,-4` (0xFE208EE3) → br_type=1, imm=0xFFFFFFFC, reg_write=0.
- out_ready=0 for 3 cycles with a valid bundle → outputs held stable, in_ready=0; release → the next instr is accepted the same cycle.
- flush=1 coincident with in_valid=1 and out_valid=1 → out_valid=0 next cycle, instr not consumed (in_ready=0).
- With RV32M=0: `mul` (0x022081B3) → illegal=1, reg_write=0. With RV32M=1 → alu_ctrl=16.
